// File: rtl/residual_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : residual_pingpong_buffer
//  Description : Two-bank ping-pong buffer for signed LPC residual blocks.
//                The predictor fills one bank while the Rice coder drains the
//                other. Blocks end on iLast or automatically at DEPTH samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module residual_pingpong_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4096,
    // Derived from DEPTH; leave at its default.
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iValid,
    input  logic [DATA_WIDTH-1:0] iResidual,
    input  logic                  iLast,
    output logic                  oReady,
    input  logic                  oEnable,
    output logic [DATA_WIDTH-1:0] oResidual,
    output logic                  oValid,
    output logic                  oLast,
    output logic [CNT_WIDTH-1:0]  oBlockLen,
    output logic [CNT_WIDTH-1:0]  counter,
    output logic                  oOverflow
);

    localparam int                c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_EMPTY    = 2'd0,
        S_FILLING  = 2'd1,
        S_FULL     = 2'd2,
        S_DRAINING = 2'd3
    } bank_state_t;

    // Both banks share one array; the bank index is the top address bit.
    logic [DATA_WIDTH-1:0] r_mem [2**(c_PTR_W+1)];

    bank_state_t            r_state0, r_state1, w_state0_nxt, w_state1_nxt;
    logic                   r_wbank, r_rbank;
    logic [c_PTR_W-1:0]     r_wptr, r_rptr;
    logic [CNT_WIDTH-1:0]   r_len0, r_len1;
    logic [CNT_WIDTH-1:0]   r_counter, r_block_len;
    logic [DATA_WIDTH-1:0]  r_dout;
    logic                   r_valid, r_last, r_overflow;

    bank_state_t            w_wstate;
    logic                   w_ready, w_accept, w_close, w_close_other;
    logic                   w_rd, w_rd_done, w_other_full;
    logic [CNT_WIDTH-1:0]   w_close_len, w_other_len;

    assign w_wstate      = r_wbank ? r_state1 : r_state0;
    assign w_ready       = (w_wstate == S_EMPTY) || (w_wstate == S_FILLING);
    assign w_accept      = iValid && w_ready;
    assign w_close       = w_accept && (iLast || (r_wptr == c_LAST_PTR));
    assign w_close_len   = CNT_WIDTH'(r_wptr) + CNT_WIDTH'(1);
    // A block closing in the non-read bank while the read bank finishes is
    // picked up on the same edge so the consumer sees no bubble.
    assign w_close_other = w_close && (r_wbank != r_rbank);

    assign w_rd          = oEnable && (r_counter != '0);
    assign w_rd_done     = w_rd && (r_counter == CNT_WIDTH'(1));
    assign w_other_full  = r_rbank ? (r_state0 == S_FULL) : (r_state1 == S_FULL);
    assign w_other_len   = r_rbank ? r_len0 : r_len1;

    // Per-bank lifecycle: write side and read side never touch the same bank.
    always_comb begin
        w_state0_nxt = r_state0;
        w_state1_nxt = r_state1;
        if (w_accept) begin
            if (r_wbank) w_state1_nxt = w_close ? S_FULL : S_FILLING;
            else         w_state0_nxt = w_close ? S_FULL : S_FILLING;
        end
        if (w_rd) begin
            if (r_rbank) w_state1_nxt = w_rd_done ? S_EMPTY : S_DRAINING;
            else         w_state0_nxt = w_rd_done ? S_EMPTY : S_DRAINING;
        end
    end

    // Bank state registers.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state0 <= S_EMPTY;
            r_state1 <= S_EMPTY;
        end else begin
            r_state0 <= w_state0_nxt;
            r_state1 <= w_state1_nxt;
        end
    end

    // Sample storage; contents need no reset since bank state gates access.
    always_ff @(posedge iClock) begin
        if (w_accept) r_mem[{r_wbank, r_wptr}] <= iResidual;
    end

    // Write pointer, bank select, stored block lengths and sticky overflow.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_wptr     <= '0;
            r_wbank    <= 1'b0;
            r_len0     <= '0;
            r_len1     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (iValid && !w_ready) r_overflow <= 1'b1;
            if (w_accept) begin
                if (w_close) begin
                    r_wptr  <= '0;
                    r_wbank <= ~r_wbank;
                    if (r_wbank) r_len1 <= w_close_len;
                    else         r_len0 <= w_close_len;
                end else begin
                    r_wptr <= r_wptr + c_PTR_W'(1);
                end
            end
        end
    end

    // Read pointer, remaining count, reported length and registered output.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_rptr      <= '0;
            r_rbank     <= 1'b0;
            r_counter   <= '0;
            r_block_len <= '0;
            r_dout      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_valid <= w_rd;
            r_last  <= w_rd_done;
            if (w_rd) r_dout <= r_mem[{r_rbank, r_rptr}];
            if (w_rd_done) begin
                r_rptr  <= '0;
                r_rbank <= ~r_rbank;
                if (w_other_full) begin
                    r_counter   <= w_other_len;
                    r_block_len <= w_other_len;
                end else if (w_close_other) begin
                    r_counter   <= w_close_len;
                    r_block_len <= w_close_len;
                end else begin
                    r_counter   <= '0;
                    r_block_len <= '0;
                end
            end else if (w_rd) begin
                r_rptr    <= r_rptr + c_PTR_W'(1);
                r_counter <= r_counter - CNT_WIDTH'(1);
            end else if (w_close && (r_wbank == r_rbank)) begin
                r_counter   <= w_close_len;
                r_block_len <= w_close_len;
            end
        end
    end

    assign oReady    = w_ready;
    assign oResidual = r_dout;
    assign oValid    = r_valid;
    assign oLast     = r_last;
    assign oBlockLen = r_block_len;
    assign counter   = r_counter;
    assign oOverflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_residual_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_residual_pingpong_buffer
//  Description : Scoreboard bench for residual_pingpong_buffer (DEPTH=8).
//                The reference model treats the buffer as a FIFO of closed
//                blocks, at most two outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_residual_pingpong_buffer;

    localparam int DW = 16;
    localparam int DP = 8;
    localparam int CW = $clog2(DP + 1);

    logic          iClock = 1'b0;
    logic          iReset = 1'b1;
    logic          iValid = 1'b0;
    logic [DW-1:0] iResidual = '0;
    logic          iLast = 1'b0;
    logic          oReady;
    logic          oEnable = 1'b0;
    logic [DW-1:0] oResidual;
    logic          oValid;
    logic          oLast;
    logic [CW-1:0] oBlockLen;
    logic [CW-1:0] counter;
    logic          oOverflow;

    residual_pingpong_buffer #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .iClock(iClock), .iReset(iReset), .iValid(iValid),
        .iResidual(iResidual), .iLast(iLast), .oReady(oReady),
        .oEnable(oEnable), .oResidual(oResidual), .oValid(oValid),
        .oLast(oLast), .oBlockLen(oBlockLen), .counter(counter),
        .oOverflow(oOverflow)
    );

    always #5 iClock = ~iClock;

    // Reference model state (updated just after each rising edge).
    logic [DW:0] exp_q [$];   // {last, data} in expected output order
    int          blk_q [$];   // lengths of closed, not fully read blocks
    int          head_rem = 0;
    int          cur_fill = 0;
    logic        exp_ovf = 1'b0;
    logic        exp_valid = 1'b0;
    logic        chk_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus the model's view of that edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic en);
        logic rd, acc, rdy, cl;
        int   tmp;
        iValid = v; iResidual = d; iLast = l; oEnable = en;
        @(posedge iClock);
        if (iReset) begin
            exp_q.delete(); blk_q.delete();
            head_rem = 0; cur_fill = 0; exp_ovf = 1'b0; exp_valid = 1'b0;
        end else begin
            rdy = (blk_q.size() < 2);
            rd  = en && (blk_q.size() > 0);
            acc = v && rdy;
            if (v && !rdy) exp_ovf = 1'b1;
            exp_valid = rd;
            if (rd) begin
                head_rem--;
                if (head_rem == 0) begin
                    tmp = blk_q.pop_front();
                    if (blk_q.size() > 0) head_rem = blk_q[0];
                end
            end
            if (acc) begin
                cur_fill++;
                cl = l || (cur_fill == DP);
                exp_q.push_back({cl, d});
                if (cl) begin
                    blk_q.push_back(cur_fill);
                    if (blk_q.size() == 1) head_rem = cur_fill;
                    cur_fill = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input logic en);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, en);
    endtask

    task automatic do_reset();
        iReset = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        iReset = 1'b0;
    endtask

    // Monitor: compares DUT outputs with the model away from the active edge.
    always @(negedge iClock) begin
        logic [DW:0] e;
        if (chk_en) begin
            chk("oValid", oValid, exp_valid);
            chk("oReady", oReady, blk_q.size() < 2);
            chk("counter", counter, blk_q.size() > 0 ? head_rem : 0);
            chk("oBlockLen", oBlockLen, blk_q.size() > 0 ? blk_q[0] : 0);
            chk("oOverflow", oOverflow, exp_ovf);
            if (oValid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("oResidual", oResidual, e[DW-1:0]);
                    chk("oLast", oLast, e[DW]);
                end
            end else begin
                chk("oLast_idle", oLast, 0);
            end
        end
    end

    initial begin
        logic [DW-1:0] s5 [5];
        logic [DW-1:0] s4 [4];
        logic          en_pat [5];
        s5 = '{16'd20, -16'sd123, 16'd31, 16'd100, 16'd16};
        s4 = '{16'd32, 16'd64, -16'sd123, 16'd31};
        en_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset state
        do_reset();
        chk_en = 1'b1;
        @(negedge iClock);
        chk("reset_oResidual", oResidual, 0);
        @(posedge iClock); #1;

        // Single 5-sample block, -123 must read back as 16'hFF85
        for (int i = 0; i < 5; i++) step(1'b1, s5[i], i == 4, 1'b0);
        chk("blocklen_after_close", oBlockLen, 5);
        idle(7, 1'b1);

        // Auto-close at DEPTH, then 3 samples into the second bank
        for (int i = 0; i < 8; i++) step(1'b1, DW'(100 + i), 1'b0, 1'b0);
        chk("autoclose_len", oBlockLen, 8);
        for (int i = 0; i < 3; i++) step(1'b1, DW'(200 + i), 1'b0, 1'b0);
        idle(9, 1'b1);
        step(1'b1, DW'(203), 1'b1, 1'b0);
        idle(6, 1'b1);

        // Ping-pong: A drains while B is written; output must be gapless
        for (int i = 1; i <= 6; i++) step(1'b1, DW'(i), i == 6, 1'b0);
        for (int i = 7; i <= 10; i++) step(1'b1, DW'(i), i == 10, 1'b1);
        idle(8, 1'b1);

        // Both banks full: oReady low, offered sample is dropped
        for (int i = 0; i < 16; i++) step(1'b1, DW'(300 + i), 1'b0, 1'b0);
        step(1'b1, -DW'(5), 1'b0, 1'b0);
        chk("overflow_set", oOverflow, 1);
        idle(18, 1'b1);

        // Enable toggling within a 4-sample block
        for (int i = 0; i < 4; i++) step(1'b1, s4[i], i == 3, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, en_pat[i]);
        idle(4, 1'b1);

        // Reset mid-drain, then a fresh block
        for (int i = 0; i < 5; i++) step(1'b1, DW'(400 + i), i == 4, 1'b0);
        idle(2, 1'b1);
        chk("pre_reset_counter", counter, 3);
        do_reset();
        chk("post_reset_overflow", oOverflow, 0);
        for (int i = 0; i < 3; i++) step(1'b1, DW'(500 + i), i == 2, 1'b0);
        idle(5, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), DW'($urandom), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) < 7);
        idle(20, 1'b1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/residual_pingpong_buffer.md
Name: residual_pingpong_buffer

Overview:
- Parametrised successor to the single-bank residual buffer in the FLAC encoder.
- Double-buffers (ping-pong) blocks of signed LPC residuals between the predictor and the Rice coder.
- While one bank is read out, the predictor keeps writing the next block into the other bank.
- Adds variable block length with an end-of-block marker, a write-side ready/stall, overflow detection, and block-length reporting.

Parameters:
- DATA_WIDTH, 16: residual width in bits, two's complement.
- DEPTH, 4096: maximum samples per bank; must be ≥ 2.
- CNT_WIDTH, $clog2(DEPTH+1): width of the count outputs; derived, not overridden.

Ports:
- iClock  in  1  system clock; all logic on its rising edge.
- iReset  in  1  synchronous, active-high reset.
- iValid  in  1  residual present on iResidual this cycle.
- iResidual  in  DATA_WIDTH  signed residual sample.
- iLast  in  1  qualifies iValid: this sample closes the current block.
- oReady  out  1  write bank can accept a sample this cycle.
- oEnable  in  1  consumer requests one sample per cycle.
- oResidual  out  DATA_WIDTH  signed sample being read out (registered).
- oValid  out  1  oResidual is valid this cycle.
- oLast  out  1  with oValid: final sample of the block.
- oBlockLen  out  CNT_WIDTH  length of the block in the read bank; 0 if none.
- counter  out  CNT_WIDTH  samples remaining in the read bank.
- oOverflow  out  1  sticky: a sample was offered while oReady was low.

Behaviour:
- Reset: both banks EMPTY; write bank = 0, read bank = 0; pointers 0.
  - oReady=1, oValid=0, oLast=0, oResidual=0, oBlockLen=0, counter=0, oOverflow=0.
  - Reset asserted mid-operation discards all stored data; it takes effect at the next edge with no drain.
- Bank states: EMPTY -> FILLING (first accepted write) -> FULL (block closed) -> DRAINING (first read) -> EMPTY (last read).
- Write side:
  - Accept = iValid & oReady. The sample is stored at wptr of the write bank, then wptr increments.
  - The block closes when iLast is accepted or when wptr = DEPTH-1 is written (auto-close at DEPTH).
  - On close, the stored length is wptr+1, the bank goes FULL, the write bank toggles, and wptr returns to 0.
  - iLast without iValid is ignored, so zero-length blocks are impossible.
  - oReady = write bank is EMPTY or FILLING, computed from registered state.
  - A bank freed by the read side becomes writable on the cycle after it is freed.
  - iValid & !oReady drops the sample and sets oOverflow; it clears only on iReset.
- Read side:
  - The read bank is readable when FULL or DRAINING.
  - counter = remaining samples; oBlockLen = stored length. Both load on the edge the bank becomes FULL if it is the read bank, otherwise when the read bank toggles onto it.
  - On an edge where oEnable=1 and counter>0: oResidual <= mem[rptr], oValid <= 1, rptr++, counter--.
  - oLast <= 1 when counter was 1.
  - The read latency is 1 cycle from oEnable to oValid.
  - oEnable=0 or counter=0: oValid <= 0 and oLast <= 0; oResidual holds its last value; position is held.
  - After the last sample, the bank goes EMPTY, the read bank toggles, and rptr returns to 0.
  - If the other bank is already FULL, counter/oBlockLen load its values on that same edge, so back-to-back reads run with no bubble.
- Simultaneous events:
  - A write close and a read free on the same edge are both honoured.
  - Both banks FULL gives oReady=0 until one bank is freed.
  - Reading and writing the same bank is impossible by construction.
- Arithmetic: pure storage with no sign manipulation. oResidual is bit-identical to the input, e.g. -123 is read back as 16'hFF85.

Test Plan (DEPTH=8 override unless stated):
- Reset then 5 samples {20,-123,31,100,16} with iLast on 16 → at the closing edge oBlockLen=5, counter=5. With oEnable held, oValid for 5 cycles in order, oLast with 16, then counter=0 and oValid=0.
- Write 8 samples with no iLast → auto-close at 8 (oBlockLen=8). The next 3 samples go to bank 1 with oReady=1 throughout.
- Ping-pong: block A {1..6}+iLast, then block B {7..10}+iLast written while A drains (oEnable=1) → output is 1..6 immediately followed by 7..10 with no idle cycle. oLast on 6 and 10; oBlockLen goes 6→4.
- Both banks full (two 8-sample blocks, oEnable=0) → oReady=0; offering -5 sets oOverflow=1 and the sample is absent from the output. After bank 0 drains, oReady=1 the following cycle.
- oEnable toggled 1,0,1,1,0 during a 4-sample block {32,64,-123,31} → oValid pattern follows with 1-cycle lag, values in order, counter decrements only on enabled cycles.
- iReset asserted mid-drain with counter=3 → next edge: counter=0, oValid=0, oBlockLen=0, oOverflow=0, oReady=1. The following new block reads back correctly.
